// File: rtl/window_filter_module_pkg.sv
// Shared sizes, FSM encoding and the saturation helper for the KxK box filter.
package window_filter_module_pkg;

    localparam int unsigned K             = 3;
    localparam int unsigned PIXEL_WIDTH   = 8;
    localparam int unsigned IMG_W         = 16;
    localparam int unsigned OUT_ROWS      = 14;
    localparam int unsigned DEF_DIV_SHIFT = 3;
    localparam int unsigned SUM_WIDTH     = PIXEL_WIDTH + $clog2(K * K);
    localparam int unsigned COL_WIDTH     = K * PIXEL_WIDTH;
    localparam int unsigned WIN_WIDTH     = K * COL_WIDTH;
    localparam int unsigned X_WIDTH       = $clog2(IMG_W);
    localparam int unsigned ROW_WIDTH     = $clog2(OUT_ROWS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Clamp a scaled window sum to the largest representable pixel.
    function automatic logic [PIXEL_WIDTH-1:0] saturate(input logic [SUM_WIDTH-1:0] v);
        return (v > SUM_WIDTH'((1 << PIXEL_WIDTH) - 1)) ? '1 : v[PIXEL_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/window_filter_module_if.sv
// Column-in / filtered-pixel-out bundle of the window filter.
interface window_filter_module_if;
    import window_filter_module_pkg::*;

    logic                   start;
    logic                   in_valid;
    logic [COL_WIDTH-1:0]   in_col;
    logic                   out_valid;
    logic [PIXEL_WIDTH-1:0] out_pix;
    logic [X_WIDTH-1:0]     out_x;
    logic                   busy;
    logic                   frame_done;

    modport master (
        output start, in_valid, in_col,
        input  out_valid, out_pix, out_x, busy, frame_done
    );

    modport slave (
        input  start, in_valid, in_col,
        output out_valid, out_pix, out_x, busy, frame_done
    );
endinterface

// File: rtl/window_filter_module_shift_reg.sv
// KxK pixel window held as K column registers; column 0 is the oldest (leftmost).
module window_shift_reg
    import window_filter_module_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_shift,
    input  logic [COL_WIDTH-1:0] i_col,
    output logic [WIN_WIDTH-1:0] o_win
);

    logic [COL_WIDTH-1:0] r_cols [K];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cols <= '{default: '0};
        end else if (i_shift) begin
            for (int c = 0; c < K - 1; c++) begin
                r_cols[c] <= r_cols[c + 1];
            end
            r_cols[K-1] <= i_col;
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_flat
        assign o_win[g*COL_WIDTH +: COL_WIDTH] = r_cols[g];
    end

endmodule

// File: rtl/window_filter_module.sv
// KxK box filter over a column stream: row-aligned sliding window, 2-stage adder pipeline.
module window_filter_module
    import window_filter_module_pkg::*;
#(
    parameter int unsigned DIV_SHIFT = DEF_DIV_SHIFT
)
(
    input  logic             clk,
    input  logic             rst,
    window_filter_module_if.slave bus
);

    state_t                 r_state, w_state_nxt;
    logic [X_WIDTH-1:0]     r_col_cnt;
    logic [ROW_WIDTH-1:0]   r_row_cnt;
    logic                   w_accept, w_col_last, w_row_last, w_emit;
    logic [WIN_WIDTH-1:0]   w_win;
    logic [COL_WIDTH-1:0]   w_cols [K];
    logic [SUM_WIDTH-1:0]   w_csum [K];
    logic [SUM_WIDTH-1:0]   r_csum [K];
    logic [SUM_WIDTH-1:0]   w_total, w_scaled;
    logic                   r_s1_vld;
    logic [X_WIDTH-1:0]     r_s1_x;
    logic                   r_out_valid, r_busy, r_frame_done;
    logic [PIXEL_WIDTH-1:0] r_out_pix;
    logic [X_WIDTH-1:0]     r_out_x;

    assign w_accept   = bus.in_valid && (r_state == ST_FILL || r_state == ST_RUN);
    assign w_col_last = (r_col_cnt == X_WIDTH'(IMG_W - 1));
    assign w_row_last = (r_row_cnt == ROW_WIDTH'(OUT_ROWS - 1));
    assign w_emit     = w_accept && (r_col_cnt >= X_WIDTH'(K - 1));

    window_shift_reg u_win (
        .clk     (clk),
        .rst     (rst),
        .i_shift (w_accept),
        .i_col   (bus.in_col),
        .o_win   (w_win)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_FILL;
            ST_FILL, ST_RUN: begin
                if (w_accept) begin
                    if (w_col_last)                          w_state_nxt = w_row_last ? ST_DONE : ST_FILL;
                    else if (r_col_cnt == X_WIDTH'(K - 1))   w_state_nxt = ST_RUN;
                end
            end
            // Hold until the last beat has left S1 so frame_done trails the final pixel.
            ST_DONE: if (!r_s1_vld) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col_cnt <= '0;
                r_row_cnt <= r_row_cnt + ROW_WIDTH'(1);
            end else begin
                r_col_cnt <= r_col_cnt + X_WIDTH'(1);
            end
        end
    end

    // Column sums use the window as it looks after this beat's shift, keeping latency at 2.
    always_comb begin
        for (int c = 0; c < K - 1; c++) begin
            w_cols[c] = w_win[(c+1)*COL_WIDTH +: COL_WIDTH];
        end
        w_cols[K-1] = bus.in_col;
        for (int c = 0; c < K; c++) begin
            w_csum[c] = '0;
            for (int r = 0; r < K; r++) begin
                w_csum[c] = w_csum[c] + SUM_WIDTH'(w_cols[c][r*PIXEL_WIDTH +: PIXEL_WIDTH]);
            end
        end
        w_total = '0;
        for (int c = 0; c < K; c++) begin
            w_total = w_total + r_csum[c];
        end
        w_scaled = w_total >> DIV_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum       <= '{default: '0};
            r_s1_vld     <= 1'b0;
            r_s1_x       <= '0;
            r_out_valid  <= 1'b0;
            r_out_pix    <= '0;
            r_out_x      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_s1_vld <= w_emit;
            if (w_emit) begin
                r_csum <= w_csum;
                r_s1_x <= r_col_cnt - X_WIDTH'(K - 1);
            end
            r_out_valid <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_pix <= saturate(w_scaled);
                r_out_x   <= r_s1_x;
            end
            r_busy       <= (w_state_nxt == ST_FILL) || (w_state_nxt == ST_RUN);
            r_frame_done <= (r_state == ST_DONE) && (w_state_nxt == ST_IDLE);
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_pix    = r_out_pix;
    assign bus.out_x      = r_out_x;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_window_filter_module.sv
// Bench for window_filter_module: two instances (DIV_SHIFT 3 and 0) against a frame-level model.
module tb_window_filter_module;
    import window_filter_module_pkg::*;

    localparam int KK = int'(K);
    localparam int PW = int'(PIXEL_WIDTH);
    localparam int CW = int'(COL_WIDTH);

    typedef struct {
        int cyc;
        int pix;
        int x;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_filter_module_if bus3 ();
    window_filter_module_if bus0 ();

    window_filter_module #(.DIV_SHIFT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
    window_filter_module #(.DIV_SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    exp_t q3[$];
    exp_t q0[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_armed = 0;
    int   m_col  = 0;
    int   m_row  = 0;
    int   m_fd   = -1;
    int   n_out  = 0;
    int   n_fd   = 0;
    int   pixbuf [IMG_W][K];

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Frame-level behaviour: which beats are accepted and what pixel each full window yields.
    task automatic model_edge(input logic st, input logic iv, input logic [CW-1:0] col, input logic r);
        int s;
        if (r) begin
            m_armed = 0; m_col = 0; m_row = 0; m_fd = -1;
            q3.delete(); q0.delete();
            return;
        end
        if (m_armed != 0 && iv) begin
            for (int rr = 0; rr < KK; rr++) pixbuf[m_col][rr] = int'(col[rr*PW +: PW]);
            if (m_col >= KK - 1) begin
                s = 0;
                for (int cc = m_col - KK + 1; cc <= m_col; cc++)
                    for (int rr = 0; rr < KK; rr++) s += pixbuf[cc][rr];
                q3.push_back('{cyc + 1, sat(s >> 3), m_col - KK + 1});
                q0.push_back('{cyc + 1, sat(s), m_col - KK + 1});
            end
            if (m_col == int'(IMG_W) - 1) begin
                m_col = 0;
                m_row++;
                if (m_row == int'(OUT_ROWS)) begin
                    m_armed = 0;
                    m_fd = cyc + 2;
                end
            end else begin
                m_col++;
            end
        end else if (m_armed == 0 && cyc > m_fd && st) begin
            m_armed = 1; m_col = 0; m_row = 0;
        end
    endtask

    task automatic chk_port(input string n, input logic ov, input logic [PIXEL_WIDTH-1:0] pix,
                            input logic [X_WIDTH-1:0] x, input logic busy, input logic fd,
                            input bit has, input exp_t h, input bit after_rst);
        chk({n, " out_valid"}, 32'(ov), 32'(has));
        if (has) begin
            chk({n, " out_pix"}, 32'(pix), 32'(h.pix));
            chk({n, " out_x"}, 32'(x), 32'(h.x));
        end
        if (after_rst) begin
            chk({n, " rst out_pix"}, 32'(pix), 32'd0);
            chk({n, " rst out_x"}, 32'(x), 32'd0);
        end
        chk({n, " busy"}, 32'(busy), 32'(m_armed));
        chk({n, " frame_done"}, 32'(fd), 32'(cyc == m_fd));
    endtask

    task automatic step(input logic st, input logic iv, input logic [CW-1:0] col, input logic r);
        bit   h3v, h0v;
        exp_t h3, h0;
        rst = r;
        bus3.start = st; bus3.in_valid = iv; bus3.in_col = col;
        bus0.start = st; bus0.in_valid = iv; bus0.in_col = col;
        @(posedge clk);
        cyc++;
        model_edge(st, iv, col, r);
        @(negedge clk);
        h3v = (q3.size() > 0) && (q3[0].cyc == cyc);
        h0v = (q0.size() > 0) && (q0[0].cyc == cyc);
        h3 = h3v ? q3[0] : '{0, 0, 0};
        h0 = h0v ? q0[0] : '{0, 0, 0};
        chk_port("ds3", bus3.out_valid, bus3.out_pix, bus3.out_x, bus3.busy, bus3.frame_done, h3v, h3, bit'(r));
        chk_port("ds0", bus0.out_valid, bus0.out_pix, bus0.out_x, bus0.busy, bus0.frame_done, h0v, h0, bit'(r));
        if (h3v) begin void'(q3.pop_front()); n_out++; end
        if (h0v) begin void'(q0.pop_front()); n_out++; end
        if (bus3.frame_done === 1'b1) n_fd++;
    endtask

    function automatic logic [CW-1:0] rand_col();
        logic [CW-1:0] c;
        for (int r = 0; r < KK; r++) c[r*PW +: PW] = PIXEL_WIDTH'($urandom);
        return c;
    endfunction

    // mode 0: all ones, 1: pixel = column index, 2: all 0xFF, else random
    task automatic feed_row(input int mode, input bit gaps, input int ncols);
        logic [CW-1:0] col;
        for (int c = 0; c < ncols; c++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, rand_col(), 1'b0);
            for (int r = 0; r < KK; r++) begin
                case (mode)
                    0:       col[r*PW +: PW] = PIXEL_WIDTH'(1);
                    1:       col[r*PW +: PW] = PIXEL_WIDTH'(c);
                    2:       col[r*PW +: PW] = '1;
                    default: col[r*PW +: PW] = PIXEL_WIDTH'($urandom);
                endcase
            end
            step(1'b0, 1'b1, col, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus3.start = 1'b0; bus3.in_valid = 1'b0; bus3.in_col = '0;
        bus0.start = 1'b0; bus0.in_valid = 1'b0; bus0.in_col = '0;

        // Reset, then beats without start must be ignored.
        repeat (3) step(1'b0, 1'b0, '0, 1'b1);
        repeat (4) step(1'b0, 1'b1, rand_col(), 1'b0);

        // Frame 1: ones row, column-index row, saturating row, then random rows with gaps.
        step(1'b1, 1'b0, '0, 1'b0);
        feed_row(0, 1'b0, int'(IMG_W));
        feed_row(1, 1'b0, int'(IMG_W));
        feed_row(2, 1'b0, int'(IMG_W));
        for (int r = 3; r < int'(OUT_ROWS); r++) feed_row(3, 1'b1, int'(IMG_W));
        for (int i = 0; i < 6; i++) step(1'b0, 1'(i % 2), rand_col(), 1'b0);
        chk("frame1 output count", 32'(n_out), 32'(2 * 196));
        chk("frame1 frame_done count", 32'(n_fd), 32'd1);

        // Frame 2: fully random with gaps.
        n_out = 0;
        step(1'b1, 1'b0, '0, 1'b0);
        for (int r = 0; r < int'(OUT_ROWS); r++) feed_row(3, 1'b1, int'(IMG_W));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, rand_col(), 1'b0);
        chk("frame2 output count", 32'(n_out), 32'(2 * 196));
        chk("frame2 frame_done count", 32'(n_fd), 32'd2);

        // Frame 3: abort mid-row with outputs in flight.
        step(1'b1, 1'b0, '0, 1'b0);
        feed_row(3, 1'b1, int'(IMG_W));
        feed_row(3, 1'b0, 5);
        step(1'b0, 1'b1, rand_col(), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rand_col(), 1'b0);
        chk("frame_done after abort", 32'(n_fd), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
